prbs8_checker: RTL and testbench
================================

PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive correct predictions required to declare lock.
REQ-002 Parameter WINDOW, default 64: length in valid bits of the loss-of-lock observation window.
REQ-003 Parameter LOSS_THRESH, default 4: errors within one window that force loss of lock.
REQ-004 CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 RESETN  input  1  asynchronous active-low reset.
REQ-006 CE  input  1  bit-valid strobe; I is sampled only when CE=1.
REQ-007 I  input  1  received serial PRBS bit.
REQ-008 CLR  input  1  synchronous clear of ERR_COUNT.
REQ-009 LOCKED  output  1  high while in LOCKED state.
REQ-010 ERR  output  1  one-cycle pulse per detected bit error while locked.
REQ-011 ERR_COUNT  output  16  saturating count of errors detected while locked.

Function
REQ-012 Polynomial x^8+x^6+x^5+x^4+1: expected bit e[n] = b[n-4]^b[n-5]^b[n-6]^b[n-8], with a period of 255.
REQ-013 History register H[7:0] holds the last 8 accepted bits, H[0] newest, so e = H[7]^H[5]^H[4]^H[3].
REQ-014 Cycles with CE=0 change no state; ERR=0 in those cycles.
REQ-015 States: SEARCH and LOCKED; reset state is SEARCH.
REQ-016 SEARCH, fill phase: the first 8 valid bits after entry shift I into H without comparison.
REQ-017 SEARCH, after fill: each valid bit is compared with e, and I is shifted into H.
REQ-018 In SEARCH, a match increments the match counter; a mismatch clears it to 0.
REQ-019 In SEARCH, a comparison made while H==0 counts as a mismatch, so an all-zero stream never locks.
REQ-020 SEARCH->LOCKED on the valid bit that brings the match counter to LOCK_COUNT; LOCKED=1 from the next cycle.
REQ-021 LOCKED (flywheel): each valid bit shifts e, not I, into H, so one corrupted input bit yields exactly one error.
REQ-022 In LOCKED, a valid bit with I!=e sets ERR=1 for exactly the following cycle (latency 1) and increments ERR_COUNT.
REQ-023 ERR_COUNT saturates at 16'hFFFF with no wrap.
REQ-024 CLR=1 sets ERR_COUNT to 0; if CLR and an error coincide, ERR_COUNT becomes 1.
REQ-025 In LOCKED, a window bit counter counts valid bits 0..WINDOW-1, and a window error counter counts errors.
REQ-026 On window wrap, both window counters clear; an error on the wrap bit counts in the new window.
REQ-027 When the window error count reaches LOSS_THRESH: go to SEARCH next cycle, and clear the fill counter, match counter and window counters.
REQ-028 On loss of lock, ERR_COUNT is retained.
REQ-029 In SEARCH, ERR stays 0 and ERR_COUNT is not incremented.

Reset
REQ-030 While RESETN=0, asynchronously: state=SEARCH, H=0, all counters=0, LOCKED=0, ERR=0, ERR_COUNT=0.
REQ-031 Reset asserted mid-operation, including while locked, discards lock; after release, full re-fill and LOCK_COUNT matches are required.
REQ-032 Release of reset is synchronised internally so that the first edge after release acts on a defined state.

Structure
REQ-033 Shared package prbs_pkg holds PRBS8_TAPS=8'hB8, PRBS8_LEN=8, and the state enum {SEARCH, LOCKED}.
REQ-034 One sub-module, prbs8_lfsr, holds H with a load-select (received/predicted) and produces e, so that the generator and checker share the tap logic.
REQ-035 All counters are registered; ERR and LOCKED are driven directly from flops.

Verification
REQ-036 Clean PRBS from seed H=8'h01, CE=1 every cycle -> LOCKED rises the cycle after valid bit 24; ERR_COUNT=0 after 1000 bits.
REQ-037 Locked, then bit 100 inverted -> a single ERR pulse, ERR_COUNT=1, LOCKED stays 1.
REQ-038 Locked, then 4 inverted bits within 64 valid bits -> LOCKED falls; clean data afterwards -> LOCKED returns 24 valid bits later, ERR_COUNT=4.
REQ-039 All-zero input for 300 bits -> LOCKED never asserts; all-ones input -> LOCKED never asserts.
REQ-040 CE high one cycle in three with the clean stream -> same lock point, counted in valid bits; CE=0 cycles leave ERR=0.
REQ-041 CLR coincident with an error (ERR_COUNT=5) -> ERR_COUNT=1; RESETN pulse while locked -> LOCKED=0 immediately.

Source files
------------

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared PRBS8 constants, state type and tap helper
package prbs_pkg;

    localparam int             PRBS8_LEN  = 8;
    localparam logic [7:0]     PRBS8_TAPS = 8'hB8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } prbs_state_e;

    // Taps 7,5,4,3 of the history give the next bit of x^8+x^6+x^5+x^4+1.
    function automatic logic prbs8_predict(input logic [PRBS8_LEN-1:0] hist);
        return ^(hist & PRBS8_TAPS);
    endfunction

endpackage

// File: rtl/prbs8_checker_if.sv
// rtl/prbs8_checker_if.sv - serial bit input and lock/error status bundle
interface prbs8_checker_if;

    logic        ce;
    logic        i;
    logic        clr;
    logic        locked;
    logic        err;
    logic [15:0] err_count;

    modport master (
        output ce, i, clr,
        input  locked, err, err_count
    );

    modport slave (
        input  ce, i, clr,
        output locked, err, err_count
    );

endinterface

// File: rtl/prbs8_lfsr.sv
// rtl/prbs8_lfsr.sv - 8-bit PRBS history with received/predicted load select
module prbs8_lfsr
    import prbs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 shift,
    input  logic                 load_pred,
    input  logic                 din,
    output logic [PRBS8_LEN-1:0] hist,
    output logic                 pred
);

    assign pred = prbs8_predict(hist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (shift) begin
            hist <= {hist[PRBS8_LEN-2:0], load_pred ? pred : din};
        end
    end

endmodule

// File: rtl/prbs8_checker.sv
// rtl/prbs8_checker.sv - PRBS8 checker with flywheel prediction and windowed loss of lock
module prbs8_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 4
) (
    input  logic           clk,
    input  logic           resetn,
    prbs8_checker_if.slave bus
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(LOSS_THRESH + 1);
    localparam int FW = $clog2(PRBS8_LEN + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LIMIT  = EW'(LOSS_THRESH);
    localparam logic [FW-1:0] FILL_DONE  = FW'(PRBS8_LEN);

    logic [1:0]           rst_sync;
    logic                 rst_int_n;
    prbs_state_e          state, state_nxt;
    logic [FW-1:0]        fill_cnt, fill_nxt;
    logic [MW-1:0]        match_cnt, match_nxt;
    logic [WW-1:0]        wbit_cnt, wbit_nxt;
    logic [EW-1:0]        werr_cnt, werr_nxt;
    logic [15:0]          err_count, count_nxt;
    logic                 err_q, locked_q, err_hit;
    logic                 shift, load_pred, pred;
    logic [PRBS8_LEN-1:0] hist;

    // Assert asynchronously, release two edges later so no flop sees a partial release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync[1];

    prbs8_lfsr u_lfsr (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .shift     (shift),
        .load_pred (load_pred),
        .din       (bus.i),
        .hist      (hist),
        .pred      (pred)
    );

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        match_nxt = match_cnt;
        wbit_nxt  = wbit_cnt;
        werr_nxt  = werr_cnt;
        count_nxt = err_count;
        shift     = 1'b0;
        load_pred = 1'b0;
        err_hit   = 1'b0;
        if (bus.ce) begin
            shift = 1'b1;
            if (state == SEARCH) begin
                if (fill_cnt != FILL_DONE) begin
                    fill_nxt = fill_cnt + FW'(1);
                end else if (bus.i == pred && hist != '0) begin
                    if (match_cnt == MATCH_LAST) begin
                        state_nxt = LOCKED;
                        match_nxt = '0;
                    end else begin
                        match_nxt = match_cnt + MW'(1);
                    end
                end else begin
                    match_nxt = '0;
                end
            end else begin
                // Flywheel: keep predicting from our own history so a bad bit is counted once.
                load_pred = 1'b1;
                err_hit   = (bus.i != pred);
                if (wbit_cnt == WIN_LAST) begin
                    wbit_nxt = '0;
                    werr_nxt = EW'(err_hit);
                end else begin
                    wbit_nxt = wbit_cnt + WW'(1);
                    werr_nxt = werr_cnt + EW'(err_hit);
                end
                if (werr_nxt == ERR_LIMIT) begin
                    state_nxt = SEARCH;
                    fill_nxt  = '0;
                    match_nxt = '0;
                    wbit_nxt  = '0;
                    werr_nxt  = '0;
                end
            end
        end
        if (bus.clr) begin
            count_nxt = {15'd0, err_hit};
        end else if (err_hit && err_count != 16'hFFFF) begin
            count_nxt = err_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= SEARCH;
            fill_cnt  <= '0;
            match_cnt <= '0;
            wbit_cnt  <= '0;
            werr_cnt  <= '0;
            err_count <= '0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            match_cnt <= match_nxt;
            wbit_cnt  <= wbit_nxt;
            werr_cnt  <= werr_nxt;
            err_count <= count_nxt;
            err_q     <= err_hit;
            locked_q  <= (state_nxt == LOCKED);
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_prbs8_checker.sv
// tb/tb_prbs8_checker.sv - directed bench for prbs8_checker with a bit-level reference model
module tb_prbs8_checker;

    localparam int LOCK_COUNT  = 16;
    localparam int WINDOW      = 64;
    localparam int LOSS_THRESH = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    prbs8_checker_if bus ();

    prbs8_checker #(
        .LOCK_COUNT  (LOCK_COUNT),
        .WINDOW      (WINDOW),
        .LOSS_THRESH (LOSS_THRESH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;
    bit   cmp_on     = 1'b0;
    int   gi         = 0;

    // Reference sequence: seed b[-8..-1] = 0000_0001, then b[n]=b[n-4]^b[n-5]^b[n-6]^b[n-8].
    logic pseq [0:262];

    logic mq [0:7];
    bit   m_lock;
    int   m_fill, m_match, m_k, m_win, m_werr, m_cnt;
    logic exp_err, exp_locked;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sbit(input int n);
        return pseq[8 + (n % 255)];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mq[k] = 1'b0;
        m_lock = 0; m_fill = 0; m_match = 0; m_k = 0; m_win = 0; m_werr = 0; m_cnt = 0;
        exp_err = 1'b0; exp_locked = 1'b0;
    endtask

    task automatic push(input logic b);
        for (int k = 0; k < 7; k++) mq[k] = mq[k+1];
        mq[7] = b;
    endtask

    task automatic model_step(input logic c, input logic b, input logic cl);
        logic e;
        logic bad;
        bit   nz;
        bad = 1'b0;
        if (c) begin
            e = mq[4] ^ mq[3] ^ mq[2] ^ mq[0];
            if (!m_lock) begin
                if (m_fill < 8) begin
                    m_fill++;
                end else begin
                    nz = 0;
                    for (int k = 0; k < 8; k++) nz |= mq[k];
                    if (b == e && nz) begin
                        m_match++;
                        if (m_match == LOCK_COUNT) begin
                            m_lock = 1; m_match = 0; m_k = 0; m_win = 0; m_werr = 0;
                        end
                    end else begin
                        m_match = 0;
                    end
                end
                push(b);
            end else begin
                bad = (b != e);
                push(e);
                if ((m_k + 1) / WINDOW != m_win) begin
                    m_win  = (m_k + 1) / WINDOW;
                    m_werr = 0;
                end
                m_k++;
                if (bad) m_werr++;
                if (m_werr == LOSS_THRESH) begin
                    m_lock = 0; m_fill = 0; m_match = 0;
                end
            end
        end
        if (cl) m_cnt = bad ? 1 : 0;
        else if (bad && m_cnt < 65535) m_cnt++;
        exp_err    = bad;
        exp_locked = m_lock;
    endtask

    task automatic cyc(input logic c, input logic b, input logic cl);
        bus.ce = c; bus.i = b; bus.clr = cl;
        @(posedge clk);
        model_step(c, b, cl);
        @(negedge clk);
        #1;
    endtask

    task automatic clean();
        cyc(1'b1, sbit(gi), 1'b0);
        gi++;
    endtask

    task automatic inject(input logic cl);
        cyc(1'b1, ~sbit(gi), cl);
        gi++;
    endtask

    task automatic wait_win_pos(input int pos);
        for (int n = 0; n < WINDOW && ((m_k + 1) % WINDOW) != pos; n++) clean();
    endtask

    always @(negedge clk) begin
        if (bus.err === 1'b1) err_pulses++;
        if (cmp_on) begin
            chk("locked", {31'd0, bus.locked}, {31'd0, exp_locked});
            chk("err", {31'd0, bus.err}, {31'd0, exp_err});
            chk("err_count", {16'd0, bus.err_count}, m_cnt);
        end
    end

    initial begin
        logic [7:0] first8;
        int         nv, p0, lock_at;
        bit         any_lock;

        for (int k = 0; k < 8; k++) pseq[k] = (k == 7);
        for (int k = 8; k < 263; k++) pseq[k] = pseq[k-4] ^ pseq[k-5] ^ pseq[k-6] ^ pseq[k-8];
        for (int k = 0; k < 8; k++) first8[7-k] = sbit(k);
        chk("prbs_first8", {24'd0, first8}, 32'h1C);

        bus.ce = 1'b0; bus.i = 1'b0; bus.clr = 1'b0;
        model_reset();
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_locked", {31'd0, bus.locked}, 0);
        chk("reset_err", {31'd0, bus.err}, 0);
        chk("reset_err_count", {16'd0, bus.err_count}, 0);
        cmp_on = 1'b1;
        resetn = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Clean stream: lock after valid bit 24, no errors over 1000 bits.
        for (int n = 0; n < 1000; n++) begin
            clean();
            if (n == 22) chk("lock_before_bit24", {31'd0, bus.locked}, 0);
            if (n == 23) chk("lock_after_bit24", {31'd0, bus.locked}, 1);
        end
        chk("clean_err_count", {16'd0, bus.err_count}, 0);

        // Single inverted bit while locked.
        wait_win_pos(5);
        p0 = err_pulses;
        inject(1'b0);
        repeat (10) clean();
        chk("single_err_pulses", err_pulses - p0, 1);
        chk("single_err_count", {16'd0, bus.err_count}, 1);
        chk("single_err_locked", {31'd0, bus.locked}, 1);

        // Four errors in one window drop lock; clean data relocks 24 valid bits later.
        wait_win_pos(5);
        cyc(1'b1, sbit(gi), 1'b1);
        gi++;
        p0 = err_pulses;
        for (int j = 0; j < 4; j++) begin
            inject(1'b0);
            if (j < 3) begin
                clean();
                clean();
            end
        end
        chk("loss_locked", {31'd0, bus.locked}, 0);
        nv = 0;
        while (!bus.locked && nv < 40) begin
            clean();
            nv++;
        end
        chk("relock_bits", nv, 24);
        chk("loss_err_pulses", err_pulses - p0, 4);
        chk("loss_err_count", {16'd0, bus.err_count}, 4);

        inject(1'b0);
        chk("count_to_5", {16'd0, bus.err_count}, 5);
        inject(1'b1);
        chk("clr_with_err", {16'd0, bus.err_count}, 1);
        repeat (3) clean();

        // Reset while locked drops LOCKED without waiting for a clock edge.
        resetn = 1'b0;
        model_reset();
        #1;
        chk("async_reset_locked", {31'd0, bus.locked}, 0);
        chk("async_reset_count", {16'd0, bus.err_count}, 0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        any_lock = 0;
        for (int n = 0; n < 300; n++) begin
            cyc(1'b1, 1'b0, 1'b0);
            any_lock |= bus.locked;
        end
        chk("zeros_no_lock", {31'd0, any_lock}, 0);
        any_lock = 0;
        for (int n = 0; n < 300; n++) begin
            cyc(1'b1, 1'b1, 1'b0);
            any_lock |= bus.locked;
        end
        chk("ones_no_lock", {31'd0, any_lock}, 0);

        // Sparse CE: lock point counted in valid bits, junk on idle cycles ignored.
        resetn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);
        gi = 0;
        nv = 0;
        lock_at = -1;
        for (int k = 0; k < 200 && lock_at < 0; k++) begin
            if (k % 3 == 0) begin
                clean();
                nv++;
            end else begin
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            if (bus.locked) lock_at = nv;
        end
        chk("ce_sparse_lock_bits", lock_at, 24);
        repeat (30) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            clean();
        end
        chk("ce_sparse_err_count", {16'd0, bus.err_count}, 0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
